// File: rtl/fsmd_pkg.sv
// Shared FSMD definitions: controller state encoding and the default burst
// geometry used by both the input loader and the output counter.
package fsmd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        DONE = 2'b10
    } fsmd_state_e;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_WORDS  = 8;
    localparam int DEF_ADDR_WIDTH = 3;

endpackage : fsmd_pkg

// File: rtl/load_data_ctrl.sv
// Operand loader: accepts a burst of NUM_WORDS words over a valid/ready
// handshake and writes them in order into the datapath register file.
module load_data_ctrl
    import fsmd_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_WORDS  = DEF_NUM_WORDS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  En_Load,
    input  logic                  IN_VALID,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    output logic                  IN_READY,
    output logic                  WR_EN,
    output logic [ADDR_WIDTH-1:0] WR_ADDR,
    output logic [DATA_WIDTH-1:0] WR_DATA,
    output logic [3:0]            Count,
    output logic                  Done_Flag,
    output logic                  Ovf_Flag
);

    // One spare bit so a 16-word burst can still be recognised as complete;
    // the Count port shows the low four bits.
    localparam logic [4:0] LAST_IDX = 5'(NUM_WORDS - 1);

    fsmd_state_e           state_r;
    fsmd_state_e           state_s;
    logic [4:0]            count_r;
    logic                  done_r;
    logic                  ovf_r;
    logic                  wr_en_r;
    logic [ADDR_WIDTH-1:0] wr_addr_r;
    logic [DATA_WIDTH-1:0] wr_data_r;
    logic                  in_ready_s;
    logic                  accept_s;
    logic                  last_beat_s;

    // Next-state decode and handshake ready.
    always_comb begin
        state_s    = state_r;
        in_ready_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (En_Load) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                in_ready_s = En_Load;
                if (!En_Load) begin
                    state_s = IDLE;
                end else if (IN_VALID && (count_r == LAST_IDX)) begin
                    state_s = DONE;
                end else begin
                    state_s = LOAD;
                end
            end
            DONE: begin
                if (!En_Load) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign accept_s    = IN_VALID & in_ready_s;
    assign last_beat_s = (count_r == LAST_IDX);

    // State register, beat counter and status flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
            count_r <= 5'd0;
            done_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            if ((state_r != IDLE) && !En_Load) begin
                count_r <= 5'd0;
                done_r  <= 1'b0;
                ovf_r   <= 1'b0;
            end else if (accept_s) begin
                count_r <= count_r + 5'd1;
                done_r  <= last_beat_s;
            end else if ((state_r == DONE) && IN_VALID) begin
                ovf_r   <= 1'b1;
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Register-file write port: one-cycle strobe per accepted beat.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= '0;
        end else begin
            wr_en_r <= accept_s;
            if (accept_s) begin
                wr_addr_r <= count_r[ADDR_WIDTH-1:0];
                wr_data_r <= IN_DATA;
            end else begin
                wr_addr_r <= wr_addr_r;
            end
        end
    end

    assign IN_READY  = in_ready_s;
    assign WR_EN     = wr_en_r;
    assign WR_ADDR   = wr_addr_r;
    assign WR_DATA   = wr_data_r;
    assign Count     = count_r[3:0];
    assign Done_Flag = done_r;
    assign Ovf_Flag  = ovf_r;

endmodule : load_data_ctrl

// File: tb/tb_load_data_ctrl.sv
// Bench for load_data_ctrl: three instances (8, 2 and 16 words) share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_load_data_ctrl;

    logic       clk;
    logic       rst;
    logic       en_load;
    logic       in_valid;
    logic [7:0] in_data;

    logic       rdy0, we0, done0, ovf0;
    logic [2:0] addr0;
    logic [7:0] data0;
    logic [3:0] cnt0;
    logic       rdy1, we1, done1, ovf1;
    logic [0:0] addr1;
    logic [7:0] data1;
    logic [3:0] cnt1;
    logic       rdy2, we2, done2, ovf2;
    logic [3:0] addr2;
    logic [7:0] data2;
    logic [3:0] cnt2;

    int n_checks = 0;
    int n_pass   = 0;

    load_data_ctrl #(.DATA_WIDTH(8), .NUM_WORDS(8), .ADDR_WIDTH(3)) u_dut8 (
        .CLK(clk), .RST(rst), .En_Load(en_load), .IN_VALID(in_valid), .IN_DATA(in_data),
        .IN_READY(rdy0), .WR_EN(we0), .WR_ADDR(addr0), .WR_DATA(data0),
        .Count(cnt0), .Done_Flag(done0), .Ovf_Flag(ovf0));

    load_data_ctrl #(.DATA_WIDTH(8), .NUM_WORDS(2), .ADDR_WIDTH(1)) u_dut2 (
        .CLK(clk), .RST(rst), .En_Load(en_load), .IN_VALID(in_valid), .IN_DATA(in_data),
        .IN_READY(rdy1), .WR_EN(we1), .WR_ADDR(addr1), .WR_DATA(data1),
        .Count(cnt1), .Done_Flag(done1), .Ovf_Flag(ovf1));

    load_data_ctrl #(.DATA_WIDTH(8), .NUM_WORDS(16), .ADDR_WIDTH(4)) u_dut16 (
        .CLK(clk), .RST(rst), .En_Load(en_load), .IN_VALID(in_valid), .IN_DATA(in_data),
        .IN_READY(rdy2), .WR_EN(we2), .WR_ADDR(addr2), .WR_DATA(data2),
        .Count(cnt2), .Done_Flag(done2), .Ovf_Flag(ovf2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: phase 0 = waiting for enable, 1 = collecting words, 2 = burst complete.
    int burst_len [3] = '{8, 2, 16};
    int m_phase   [3];
    int m_words   [3];
    int m_ovf     [3];
    int m_we      [3];
    int m_addr    [3];
    int m_data    [3];
    int m_done    [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_phase[k] = 0; m_words[k] = 0; m_ovf[k] = 0; m_done[k] = 0;
            m_we[k] = 0; m_addr[k] = 0; m_data[k] = 0;
        end
    endtask

    // Applies one clock edge worth of protocol rules to every model copy.
    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 3; k++) begin
                m_we[k] = 0;
                if (m_phase[k] == 0) begin
                    if (en_load) m_phase[k] = 1;
                end else if (!en_load) begin
                    m_phase[k] = 0; m_words[k] = 0; m_done[k] = 0; m_ovf[k] = 0;
                end else if (m_phase[k] == 1) begin
                    if (in_valid) begin
                        m_we[k]   = 1;
                        m_addr[k] = m_words[k];
                        m_data[k] = in_data;
                        m_words[k]++;
                        if (m_words[k] == burst_len[k]) begin
                            m_phase[k] = 2;
                            m_done[k]  = 1;
                        end
                    end
                end else if (in_valid) begin
                    m_ovf[k] = 1;
                end
            end
        end
    endtask

    task automatic check_ready();
        check("d8_ready",  32'(rdy0), 32'(m_phase[0] == 1 && en_load));
        check("d2_ready",  32'(rdy1), 32'(m_phase[1] == 1 && en_load));
        check("d16_ready", 32'(rdy2), 32'(m_phase[2] == 1 && en_load));
    endtask

    task automatic check_outputs();
        check("d8_we",    32'(we0),   32'(m_we[0]));
        check("d8_addr",  32'(addr0), 32'(m_addr[0]));
        check("d8_data",  32'(data0), 32'(m_data[0]));
        check("d8_count", 32'(cnt0),  32'(m_words[0] % 16));
        check("d8_done",  32'(done0), 32'(m_done[0]));
        check("d8_ovf",   32'(ovf0),  32'(m_ovf[0]));
        check("d2_we",    32'(we1),   32'(m_we[1]));
        check("d2_addr",  32'(addr1), 32'(m_addr[1]));
        check("d2_data",  32'(data1), 32'(m_data[1]));
        check("d2_count", 32'(cnt1),  32'(m_words[1] % 16));
        check("d2_done",  32'(done1), 32'(m_done[1]));
        check("d2_ovf",   32'(ovf1),  32'(m_ovf[1]));
        check("d16_we",   32'(we2),   32'(m_we[2]));
        check("d16_addr", 32'(addr2), 32'(m_addr[2]));
        check("d16_data", 32'(data2), 32'(m_data[2]));
        check("d16_count",32'(cnt2),  32'(m_words[2] % 16));
        check("d16_done", 32'(done2), 32'(m_done[2]));
        check("d16_ovf",  32'(ovf2),  32'(m_ovf[2]));
    endtask

    // One cycle: drive inputs after the falling edge, check ready, clock, check registers.
    task automatic step(input logic r, input logic en, input logic v, input logic [7:0] d);
        rst = r; en_load = en; in_valid = v; in_data = d;
        #1;
        check_ready();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        rst = 1'b1; en_load = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        model_reset();
        @(negedge clk);

        // Reset, then a back-to-back burst of 0x10.. (extra beats overrun the small instances).
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b1, 8'(8'h10 + i));
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'hEE);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Gapped stream.
        step(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, (i % 2) == 0, 8'(8'h40 + i));
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Abort after three words with IN_VALID held, then reload.
        step(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 8'(8'h60 + i));
        step(1'b0, 1'b0, 1'b1, 8'h63);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 18; i++) step(1'b0, 1'b1, 1'b1, 8'(8'h70 + i));
        step(1'b0, 1'b0, 1'b1, 8'h00);

        // Reset mid-burst after five words, then a full burst.
        step(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 8'(8'h90 + i));
        step(1'b1, 1'b1, 1'b1, 8'h95);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 1'b1, 8'(8'hA0 + i));
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Randomised traffic with occasional aborts and resets.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 15) != 0,
                 $urandom_range(0, 1) == 1,
                 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_load_data_ctrl
